// File: rtl/gpu_ingress_queue.sv
// rtl/gpu_ingress_queue.sv - GPU ingress FIFO with loopback drop and gap-paced issue to the leaf router
module gpu_ingress_queue #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0010,
  parameter int         ROUTER_ID  = 3,
  parameter int         ISSUE_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] gpu_in_data,
  input  logic              gpu_in_valid,
  input  logic [5:0]        gpu_dest_addr,
  output logic              gpu_in_ready,
  output logic [DWIDTH-1:0] rtr_out_data,
  output logic              rtr_out_valid,
  output logic [5:0]        rtr_dest_addr,
  input  logic              rtr_busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [4:0]        fifo_count,
  output logic [7:0]        drop_count
);
  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         EW        = DWIDTH + 6;
  localparam logic [5:0] SELF_ADDR = {GROUP_ID, 2'(ROUTER_ID)};
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);
  localparam logic [3:0] GAP_LOAD  = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        gap_q, gap_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [4:0]        count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [5:0]        dest_q, dest_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];

  logic          accept, is_self, push, drop, issue, can_issue;
  logic [EW-1:0] head;

  assign fifo_full     = (count_q == DEPTH_CNT);
  assign fifo_empty    = (count_q == 5'd0);
  assign gpu_in_ready  = !fifo_full;
  assign fifo_count    = count_q;
  assign drop_count    = drop_q;
  assign rtr_out_valid = valid_q;
  assign rtr_out_data  = data_q;
  assign rtr_dest_addr = dest_q;
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    accept    = gpu_in_valid && gpu_in_ready;
    is_self   = (gpu_dest_addr == SELF_ADDR);
    push      = accept && !is_self;
    drop      = accept && is_self;
    can_issue = !fifo_empty && !rtr_busy;
  end

  // The last GAP cycle makes the IDLE decision itself so pulses land ISSUE_GAP+1 cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_issue) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ISSUE_GAP > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else if (can_issue) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (can_issue) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + 5'(push) - 5'(issue);
    drop_d   = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    valid_d  = issue;
    data_d   = issue ? head[DWIDTH-1:0] : data_q;
    dest_d   = issue ? head[EW-1:DWIDTH] : dest_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gap_q    <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      drop_q   <= 8'd0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      dest_q   <= 6'd0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
    end
  end

  // Storage needs no reset: count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {gpu_dest_addr, gpu_in_data};
    end
  end
endmodule

// File: tb/tb_gpu_ingress_queue.sv
// tb/tb_gpu_ingress_queue.sv - directed self-checking bench for gpu_ingress_queue
module tb_gpu_ingress_queue;
  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic [5:0]  in_dest;
  logic        busy;
  logic        in_ready, out_valid, full, empty;
  logic [15:0] out_data;
  logic [5:0]  out_dest;
  logic [4:0]  count;
  logic [7:0]  drops;

  logic [15:0] g0_data;
  logic        g0_valid;
  logic [5:0]  g0_dest;
  logic        g0_busy;
  logic        g0_ready, g0_out_valid, g0_full, g0_empty;
  logic [15:0] g0_out_data;
  logic [5:0]  g0_out_dest;
  logic [4:0]  g0_count;
  logic [7:0]  g0_drops;

  int vectors;
  int miscompares;
  int budget;
  int mon_n;
  int mon_last;
  logic saw_valid;

  gpu_ingress_queue u_dut (
    .clk(clk), .reset(reset),
    .gpu_in_data(in_data), .gpu_in_valid(in_valid), .gpu_dest_addr(in_dest),
    .gpu_in_ready(in_ready),
    .rtr_out_data(out_data), .rtr_out_valid(out_valid), .rtr_dest_addr(out_dest),
    .rtr_busy(busy),
    .fifo_full(full), .fifo_empty(empty), .fifo_count(count), .drop_count(drops)
  );

  gpu_ingress_queue #(.ISSUE_GAP(0)) u_dut_g0 (
    .clk(clk), .reset(reset),
    .gpu_in_data(g0_data), .gpu_in_valid(g0_valid), .gpu_dest_addr(g0_dest),
    .gpu_in_ready(g0_ready),
    .rtr_out_data(g0_out_data), .rtr_out_valid(g0_out_valid), .rtr_dest_addr(g0_out_dest),
    .rtr_busy(g0_busy),
    .fifo_full(g0_full), .fifo_empty(g0_empty), .fifo_count(g0_count), .drop_count(g0_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; busy = 1'b0;
    in_valid = 1'b1; in_data = 16'hA5A5; in_dest = 6'b000101;
    g0_valid = 1'b0; g0_data = 16'h0; g0_dest = 6'h0; g0_busy = 1'b0;

    // reset state, with a packet offered that must not be taken
    idle(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 16'h0);
    check("rst_dest", out_dest, 6'h0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 5'd0);
    check("rst_drop", drops, 8'd0);
    check("rst_ready", in_ready, 1'b1);

    // single packet accepted on first edge after reset release
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("single_count", count, 5'd1);
    check("single_early", out_valid, 1'b0);
    @(negedge clk);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 16'hA5A5);
    check("single_dest", out_dest, 6'b000101);
    check("single_count0", count, 5'd0);
    @(negedge clk);
    check("single_width", out_valid, 1'b0);
    check("single_hold", out_data, 16'hA5A5);
    idle(8);

    // loopback drops and saturation
    in_valid = 1'b1; in_data = 16'hDEAD; in_dest = 6'b001011;
    check("drop_ready", in_ready, 1'b1);
    @(negedge clk);
    check("drop_one", drops, 8'd1);
    check("drop_fifo", count, 5'd0);
    saw_valid = 1'b0;
    repeat (299) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    in_valid = 1'b0;
    check("drop_sat", drops, 8'd255);
    check("drop_no_issue", saw_valid, 1'b0);
    check("drop_empty", empty, 1'b1);
    idle(4);

    // burst of 10 with ISSUE_GAP=4
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          in_valid = 1'b1;
          in_data  = 16'(16'h1000 + k);
          in_dest  = 6'(6'h10 + k);
          budget   = 0;
          while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
          end
          check("burst_ready", in_ready, 1'b1);
          @(negedge clk);
        end
        in_valid = 1'b0;
        check("burst_count8", count, 5'd8);
        check("burst_full", full, 1'b1);
        check("burst_ready_low", in_ready, 1'b0);
      end
      begin
        mon_n = 0; mon_last = 0;
        for (int c = 0; c < 80; c++) begin
          @(negedge clk);
          if (out_valid) begin
            check("burst_data", out_data, 32'h1000 + mon_n);
            check("burst_dest", out_dest, 32'h10 + mon_n);
            if (mon_n > 0) check("burst_spacing", c - mon_last, 5);
            mon_last = c;
            mon_n++;
          end
        end
        check("burst_issued", mon_n, 10);
      end
    join

    // rtr_busy holds issue off for 20 cycles
    busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h2000 + k);
      in_dest  = 6'(6'h20 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    saw_valid = 1'b0;
    repeat (17) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("busy_no_pulse", saw_valid, 1'b0);
    check("busy_count", count, 5'd3);
    busy = 1'b0;
    @(negedge clk);
    check("busy_first", out_valid, 1'b1);
    check("busy_first_data", out_data, 16'h2000);
    check("busy_count2", count, 5'd2);
    idle(12);
    check("busy_drained", count, 5'd0);
    check("busy_last_data", out_data, 16'h2002);
    idle(6);

    // reset asserted while in GAP with 4 entries queued
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h5000 + k);
      in_dest  = 6'(6'h28 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rg_count5", count, 5'd5);
    busy = 1'b0;
    @(negedge clk);
    check("rg_issue", out_valid, 1'b1);
    check("rg_issue_data", out_data, 16'h5000);
    idle(2);
    check("rg_gap_valid", out_valid, 1'b0);
    check("rg_count4", count, 5'd4);
    #1 reset = 1'b0;
    #1;
    check("rg_valid", out_valid, 1'b0);
    check("rg_data", out_data, 16'h0);
    check("rg_dest", out_dest, 6'h0);
    check("rg_empty", empty, 1'b1);
    check("rg_count", count, 5'd0);
    check("rg_drop", drops, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 16'h3C3C; in_dest = 6'h07;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_count", count, 5'd1);
    check("post_early", out_valid, 1'b0);
    @(negedge clk);
    check("post_valid", out_valid, 1'b1);
    check("post_data", out_data, 16'h3C3C);
    check("post_dest", out_dest, 6'h07);
    idle(8);

    // ISSUE_GAP=0 instance: back-to-back issue from a full queue
    g0_busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      g0_valid = 1'b1;
      g0_data  = 16'(16'h4000 + k);
      g0_dest  = 6'(6'h30 + k);
      @(negedge clk);
    end
    check("g0_full", g0_full, 1'b1);
    check("g0_ready_low", g0_ready, 1'b0);
    check("g0_idle", g0_out_valid, 1'b0);
    g0_busy = 1'b0;
    g0_data = 16'h4008; g0_dest = 6'h38;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("g0_valid", g0_out_valid, 1'b1);
      check("g0_data", g0_out_data, 32'h4000 + i);
      check("g0_count", g0_count, 5'd7);
      g0_data = 16'(16'h4008 + i);
      g0_dest = 6'(6'h38 + i);
    end
    g0_valid = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
